jk_bank_ctrl: RTL and testbench
===============================

// Module: jk_bank_ctrl
// PURPOSE
//  Round-robin command controller for a WIDTH-bit bank of jkff cells (negedge-clocked, shared clk).
//  Arbitrates NREQ requesters issuing hold/clear/set/toggle on one bank bit, drives the bank j/k
//  vectors for exactly one clk cycle, keeps a shadow copy of expected q, checks bank q feedback.
// PARAMETERS
//  NREQ   4   number of requesters
//  WIDTH  8   number of jkff cells in bank
//  IDXW   3   bit-index width, = clog2(WIDTH)
// PORTS
//  clk        in   1          clock, all state updates on posedge
//  rst        in   1          synchronous, active-high reset
//  req_valid  in   NREQ       request per requester
//  req_op     in   2*NREQ     {j,k} per requester: 00 hold, 01 clear, 10 set, 11 toggle
//  req_idx    in   IDXW*NREQ  target bank bit per requester
//  req_ready  out  NREQ       one-hot accept pulse, 1 cycle
//  j_out      out  WIDTH      to bank j inputs
//  k_out      out  WIDTH      to bank k inputs
//  q_in       in   WIDTH      bank q feedback
//  shadow_q   out  WIDTH      expected bank state
//  busy       out  1          1 in any state except IDLE
//  err        out  1          sticky q_in/shadow mismatch flag
//  err_idx    out  IDXW       lowest mismatching bit of first error
// BEHAVIOUR
//  - While rst=1: state<=INIT, shadow_q=0, rr_ptr=0, err=0, err_idx=0; j_out=k_out=0,
//    req_ready=0 (forced). busy=1.
//  - FSM: INIT -> IDLE; IDLE -(any req_valid)-> DRIVE -> CHECK -> IDLE.
//  - INIT (1 cycle): k_out=all ones, j_out=0 (clears bank to match shadow 0); no grants.
//  - IDLE: busy=0, j_out=k_out=0. If any req_valid: grant g = first valid at/after rr_ptr (wrap),
//    latch op/idx of g, rr_ptr<=g+1 mod NREQ, go DRIVE. No valid: stay.
//  - DRIVE: req_ready[g]=1; only bit idx of j_out/k_out = latched op, all others 0. Bank captures
//    on the negedge inside this cycle. At posedge: shadow_q[idx] <= 0/1/~shadow per clear/set/toggle.
//  - CHECK: j_out=k_out=0; compare q_in with shadow_q. Mismatch and err=0 -> err<=1, err_idx<=lowest
//    mismatching bit. err=1 -> err_idx frozen. err cleared only by rst.
//  - j_out/k_out decoded from registered state/op/idx only (glitch-free); stable across negedge.
//  - Handshake: requester holds req_valid/op/idx stable until it sees req_ready=1; may drop or change
//    them from the next cycle. req_valid sampled only in IDLE. Throughput: 1 command per 3 cycles.
//  - hold (00): full sequence, req_ready pulsed, no j/k asserted, shadow unchanged, check performed.
//  - idx >= WIDTH: treated as hold; acknowledged, no bank effect.
//  - Dropping req_valid before ready: allowed only in IDLE before grant; once latched the command
//    completes regardless.
//  - rst mid-DRIVE/CHECK: command aborted, pending state discarded, shadow=0, re-enter INIT.
//  - rr_ptr advances only on grant; a lone requester is granted back-to-back every 3 cycles.
// TESTING
//  1 rst=1 two cycles, release -> cycle 1: k_out=8'hFF, j_out=0, busy=1; cycle 2: IDLE, busy=0,
//    shadow_q=0.
//  2 req0 set idx3 -> DRIVE: req_ready=4'b0001, j_out=8'h08, k_out=0; then shadow_q=8'h08, err=0.
//  3 all 4 valid, toggle idx0..3, held continuously -> grants 0,1,2,3,0 every 3 cycles;
//    shadow_q=8'h0F after 4.
//  4 toggle idx7 twice; then req op=00 idx=7 -> shadow 8'h80, 8'h00, 8'h00; hold has j_out=k_out=0.
//  5 bank model bit5 stuck 0, set idx5 -> err=1, err_idx=5 after CHECK; later mismatch on bit6
//    leaves err_idx=5.
//  6 rst=1 during DRIVE of set idx2 -> no further req_ready, shadow_q=0, INIT k_out=8'hFF next,
//    then IDLE.

Source files
------------

// File: rtl/jk_bank_ctrl.sv
`default_nettype none
// ============================================================================
// jk_bank_ctrl : round-robin j/k command controller with shadow-state checking
// Rev 1.0
// ============================================================================
module jk_bank_ctrl #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [IDXW*NREQ-1:0] req_idx,
  output logic [NREQ-1:0]      req_ready,
  output logic [WIDTH-1:0]     j_out,
  output logic [WIDTH-1:0]     k_out,
  input  logic [WIDTH-1:0]     q_in,
  output logic [WIDTH-1:0]     shadow_q,
  output logic                 busy,
  output logic                 err,
  output logic [IDXW-1:0]      err_idx
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_DRIVE = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_rr_ptr, r_grant, w_grant, w_ptr_nxt;
  logic [PW:0]      w_cand;
  logic [1:0]       r_op, w_op_sel;
  logic [IDXW-1:0]  r_idx, w_idx_sel, w_err_idx;
  logic             w_idx_ok, w_any_valid;
  logic [WIDTH-1:0] r_shadow, w_shadow_nxt, w_mismatch;
  logic             r_err;
  logic [IDXW-1:0]  r_err_idx;

  assign w_any_valid = |req_valid;

  // Search from rr_ptr upward with wrap; the smallest offset wins.
  always_comb begin
    w_grant = '0;
    w_cand  = '0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      w_cand = {1'b0, r_rr_ptr} + (PW+1)'(o);
      if (w_cand >= (PW+1)'(NREQ)) w_cand = w_cand - (PW+1)'(NREQ);
      if (req_valid[w_cand[PW-1:0]]) w_grant = w_cand[PW-1:0];
    end
  end

  always_comb begin
    w_op_sel  = '0;
    w_idx_sel = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (w_grant == PW'(r)) begin
        w_op_sel  = req_op[2*r +: 2];
        w_idx_sel = req_idx[IDXW*r +: IDXW];
      end
    end
  end

  assign w_ptr_nxt = (w_grant == PW'(NREQ - 1)) ? '0 : w_grant + 1'b1;

  generate
    if (WIDTH < (1 << IDXW)) begin : g_idx_range
      assign w_idx_ok = (int'(w_idx_sel) < WIDTH);
    end else begin : g_idx_full
      assign w_idx_ok = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_INIT;
    else     r_state <= w_state_nxt;
  end

  // j/k come only from registers so they hold steady through the bank's negedge.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    j_out       = '0;
    k_out       = '0;
    case (r_state)
      S_INIT: begin
        k_out       = '1;
        w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (w_any_valid) w_state_nxt = S_DRIVE;
      end
      S_DRIVE: begin
        for (int r = 0; r < NREQ; r++)
          if (r_grant == PW'(r)) req_ready[r] = 1'b1;
        for (int b = 0; b < WIDTH; b++) begin
          if (r_idx == IDXW'(b)) begin
            j_out[b] = r_op[1];
            k_out[b] = r_op[0];
          end
        end
        w_state_nxt = S_CHECK;
      end
      S_CHECK: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT;
    endcase
    if (rst) begin
      req_ready = '0;
      j_out     = '0;
      k_out     = '0;
    end
  end

  always_comb begin
    w_shadow_nxt = r_shadow;
    for (int b = 0; b < WIDTH; b++) begin
      if (r_idx == IDXW'(b)) begin
        case (r_op)
          2'b01:   w_shadow_nxt[b] = 1'b0;
          2'b10:   w_shadow_nxt[b] = 1'b1;
          2'b11:   w_shadow_nxt[b] = ~r_shadow[b];
          default: w_shadow_nxt[b] = r_shadow[b];
        endcase
      end
    end
  end

  assign w_mismatch = q_in ^ r_shadow;

  always_comb begin
    w_err_idx = '0;
    for (int b = WIDTH - 1; b >= 0; b--)
      if (w_mismatch[b]) w_err_idx = IDXW'(b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow  <= '0;
      r_rr_ptr  <= '0;
      r_grant   <= '0;
      r_op      <= '0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
    end else begin
      if (r_state == S_IDLE && w_any_valid) begin
        r_grant  <= w_grant;
        // Out-of-range targets are acknowledged but behave as hold.
        r_op     <= w_idx_ok ? w_op_sel : 2'b00;
        r_idx    <= w_idx_sel;
        r_rr_ptr <= w_ptr_nxt;
      end
      if (r_state == S_DRIVE) r_shadow <= w_shadow_nxt;
      if (r_state == S_CHECK && !r_err && (|w_mismatch)) begin
        r_err     <= 1'b1;
        r_err_idx <= w_err_idx;
      end
    end
  end

  assign shadow_q = r_shadow;
  assign busy     = rst || (r_state != S_IDLE);
  assign err      = r_err;
  assign err_idx  = r_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_ctrl.sv
`default_nettype none
// ============================================================================
// tb_jk_bank_ctrl : bench for jk_bank_ctrl with a negedge jkff bank model
// Rev 1.0
// ============================================================================
module tb_jk_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [11:0] req_idx;
  logic [3:0]  req_ready;
  logic [7:0]  j_out, k_out, q_in, shadow_q;
  logic        busy, err;
  logic [2:0]  err_idx;

  logic [7:0]  bank   = 8'hA5;
  logic [7:0]  stuck0 = 8'h00;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  typedef struct {
    int         r;
    logic [1:0] op;
    logic [2:0] idx;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] sh;
  } vec_t;

  vec_t tbl [6];

  jk_bank_ctrl #(.NREQ(4), .WIDTH(8), .IDXW(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
    .req_ready(req_ready), .j_out(j_out), .k_out(k_out), .q_in(q_in),
    .shadow_q(shadow_q), .busy(busy), .err(err), .err_idx(err_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank of jkff cells capturing on the falling edge; stuck0 forces q bits low.
  always @(negedge clk) begin
    for (int b = 0; b < 8; b++) begin
      case ({j_out[b], k_out[b]})
        2'b01:   bank[b] <= 1'b0;
        2'b10:   bank[b] <= 1'b1;
        2'b11:   bank[b] <= ~bank[b];
        default: bank[b] <= bank[b];
      endcase
    end
  end
  assign q_in = bank & ~stuck0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [2:0] idx);
    req_valid = 4'(1 << r);
    req_op    = 8'({6'b0, op}) << (2 * r);
    req_idx   = 12'({9'b0, idx}) << (3 * r);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    tick;
    tick;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_jk", 32'({j_out, k_out}), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_shadow", 32'(shadow_q), 0);
    chk("rst_err", 32'({err, err_idx}), 0);
    rst = 1'b0;
    #1;
    chk("init_k", 32'(k_out), 32'hFF);
    chk("init_j", 32'(j_out), 0);
    chk("init_busy", 32'(busy), 1);
    tick;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_shadow", 32'(shadow_q), 0);
    chk("idle_jk", 32'({j_out, k_out}), 0);
  endtask

  // Assumes the controller is idle; walks one command through DRIVE and CHECK.
  task automatic run_cmd(input vec_t v, input string tag);
    set_req(v.r, v.op, v.idx);
    tick;
    chk({tag, "_ready"}, 32'(req_ready), 32'(1 << v.r));
    chk({tag, "_j"}, 32'(j_out), 32'(v.j));
    chk({tag, "_k"}, 32'(k_out), 32'(v.k));
    req_valid = '0;
    tick;
    chk({tag, "_chk_jk"}, 32'({j_out, k_out}), 0);
    chk({tag, "_shadow"}, 32'(shadow_q), 32'(v.sh));
    tick;
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  logic [7:0]  msh;
  logic [3:0]  exp_rdy, prev_valid, prev_rdy;
  logic [1:0]  d_op [4];
  logic [2:0]  d_idx [4];
  logic [3:0]  d_valid;
  int          rr, last_rdy, g, c, last, waited;
  logic [1:0]  gop;
  logic [2:0]  gidx;

  initial begin
    req_valid = '0;
    req_op    = '0;
    req_idx   = '0;

    tbl[0] = '{0, 2'b10, 3'd3, 8'h08, 8'h00, 8'h08};
    tbl[1] = '{1, 2'b01, 3'd3, 8'h00, 8'h08, 8'h00};
    tbl[2] = '{2, 2'b11, 3'd7, 8'h80, 8'h80, 8'h80};
    tbl[3] = '{3, 2'b11, 3'd7, 8'h80, 8'h80, 8'h00};
    tbl[4] = '{1, 2'b00, 3'd7, 8'h00, 8'h00, 8'h00};
    tbl[5] = '{2, 2'b10, 3'd0, 8'h01, 8'h00, 8'h01};

    do_reset;
    for (int i = 0; i < 6; i++) begin
      run_cmd(tbl[i], $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_err", i), 32'(err), 0);
    end

    // All four requesters toggle bits 0..3 while holding valid continuously.
    do_reset;
    req_valid = 4'hF;
    req_op    = 8'hFF;
    req_idx   = {3'd3, 3'd2, 3'd1, 3'd0};
    last = 0;
    for (int n = 0; n < 5; n++) begin
      waited = 0;
      do begin
        tick;
        waited++;
      end while (req_ready == 4'b0 && waited < 6);
      chk($sformatf("rr_grant%0d", n), 32'(req_ready), 32'(1 << (n % 4)));
      if (n > 0) chk($sformatf("rr_spacing%0d", n), 32'(cyc - last), 3);
      if (n == 4) chk("rr_shadow", 32'(shadow_q), 32'h0F);
      last = cyc;
    end
    req_valid = '0;
    tick;
    chk("rr_shadow5", 32'(shadow_q), 32'h0E);
    tick;

    // Stuck-at-0 bank bit: first error index is captured, later ones ignored.
    do_reset;
    stuck0 = 8'h20;
    run_cmd('{0, 2'b10, 3'd5, 8'h20, 8'h00, 8'h20}, "stuck5");
    chk("stuck5_err", 32'(err), 1);
    chk("stuck5_idx", 32'(err_idx), 5);
    run_cmd('{1, 2'b01, 3'd5, 8'h00, 8'h20, 8'h00}, "clr5");
    stuck0 = 8'h60;
    run_cmd('{2, 2'b10, 3'd6, 8'h40, 8'h00, 8'h40}, "stuck6");
    chk("stuck6_err", 32'(err), 1);
    chk("stuck6_idx", 32'(err_idx), 5);
    stuck0 = 8'h00;

    // Reset landing in the middle of a command.
    do_reset;
    set_req(0, 2'b10, 3'd2);
    tick;
    chk("abort_pre_ready", 32'(req_ready), 1);
    rst = 1'b1;
    #1;
    chk("abort_ready", 32'(req_ready), 0);
    chk("abort_jk", 32'({j_out, k_out}), 0);
    req_valid = '0;
    tick;
    chk("abort_shadow", 32'(shadow_q), 0);
    chk("abort_ready2", 32'(req_ready), 0);
    rst = 1'b0;
    #1;
    chk("abort_init_k", 32'(k_out), 32'hFF);
    chk("abort_ready3", 32'(req_ready), 0);
    tick;
    chk("abort_idle", 32'(busy), 0);
    chk("abort_shadow2", 32'(shadow_q), 0);
    chk("abort_ready4", 32'(req_ready), 0);

    // Randomized traffic against a round-robin / shadow reference model.
    do_reset;
    msh = '0;
    rr = 0;
    last_rdy = cyc - 3;
    prev_valid = '0;
    prev_rdy = '0;
    d_valid = '0;
    for (int r = 0; r < 4; r++) begin
      d_op[r]  = '0;
      d_idx[r] = '0;
    end
    for (int t = 0; t < 400; t++) begin
      tick;
      exp_rdy = '0;
      g = -1;
      if (prev_valid != 4'b0 && (cyc - last_rdy) >= 3) begin
        for (int o = 0; o < 4; o++) begin
          c = (rr + o) % 4;
          if (g < 0 && prev_valid[c]) g = c;
        end
        exp_rdy = 4'(1 << g);
      end
      chk("rand_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rand_shadow", 32'(shadow_q), 32'(msh));
      chk("rand_err", 32'(err), 0);
      if (g >= 0) begin
        gop  = d_op[g];
        gidx = d_idx[g];
        chk("rand_j", 32'(j_out), gop[1] ? 32'(1 << gidx) : 0);
        chk("rand_k", 32'(k_out), gop[0] ? 32'(1 << gidx) : 0);
        case (gop)
          2'b01:   msh[gidx] = 1'b0;
          2'b10:   msh[gidx] = 1'b1;
          2'b11:   msh[gidx] = ~msh[gidx];
          default: msh = msh;
        endcase
        rr = (g + 1) % 4;
        last_rdy = cyc;
      end else if (cyc - last_rdy != 1) begin
        chk("rand_jk_quiet", 32'({j_out, k_out}), 0);
      end
      for (int r = 0; r < 4; r++) begin
        if (prev_rdy[r]) begin
          d_valid[r] = 1'($urandom_range(1, 0));
          d_op[r]    = 2'($urandom_range(3, 0));
          d_idx[r]   = 3'($urandom_range(7, 0));
        end else if (!d_valid[r] && $urandom_range(9, 0) < 3) begin
          d_valid[r] = 1'b1;
          d_op[r]    = 2'($urandom_range(3, 0));
          d_idx[r]   = 3'($urandom_range(7, 0));
        end
      end
      prev_rdy = req_ready;
      req_valid = d_valid;
      req_op  = {d_op[3], d_op[2], d_op[1], d_op[0]};
      req_idx = {d_idx[3], d_idx[2], d_idx[1], d_idx[0]};
      prev_valid = d_valid;
    end
    req_valid = '0;
    tick;
    tick;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
